// File: rtl/regfile_cmd_if.sv
// ---------------------------------------------------------------------------
// regfile_cmd_if
// Groups the bus signals around the command sequencer:
//   UART RX : RX_P_DATA, RX_D_VLD
//   RegFile : Address, WR_En, RD_EN, WrData, RdData, RdData_Vaild
//   ALU     : ALU_FUN, ALU_EN, ALU_OUT, ALU_OUT_VLD
//   UART TX : TX_P_DATA, TX_D_VLD, TX_BUSY
// master modport = sequencer side, slave modport = peripheral side.
// ---------------------------------------------------------------------------
interface regfile_cmd_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0]   RX_P_DATA;
  logic                    RX_D_VLD;
  logic [ADDR_WIDTH-1:0]   Address;
  logic                    WR_En;
  logic                    RD_EN;
  logic [DATA_WIDTH-1:0]   WrData;
  logic [DATA_WIDTH-1:0]   RdData;
  logic                    RdData_Vaild;
  logic [FUN_WIDTH-1:0]    ALU_FUN;
  logic                    ALU_EN;
  logic [2*DATA_WIDTH-1:0] ALU_OUT;
  logic                    ALU_OUT_VLD;
  logic [DATA_WIDTH-1:0]   TX_P_DATA;
  logic                    TX_D_VLD;
  logic                    TX_BUSY;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RdData, RdData_Vaild, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
    output Address, WR_En, RD_EN, WrData, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RdData, RdData_Vaild, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
    input  Address, WR_En, RD_EN, WrData, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD
  );
endinterface

// File: rtl/regfile_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_cmd_ctrl
// Command sequencer between UART RX/TX, the 16x8 register file and the ALU.
// Frames (first byte is the command):
//   AA addr data   -> register write
//   BB addr        -> register read, one byte returned on TX
//   CC a b fun     -> write REG0=a, REG1=b, run ALU, two bytes returned (LSB first)
//   DD fun         -> run ALU on current REG0/REG1, two bytes returned
// Ports:
//   CLK          system clock
//   RST          synchronous active-high reset
//   bus          regfile_cmd_if.master (RX, register file, ALU and TX signals)
//   dbg_state_o  current FSM state encoding
// Build option: define REGFILE_CMD_TIMEOUT_EN to abandon a partial frame after
// TIMEOUT_CYCLES cycles without a byte; otherwise the FSM waits indefinitely.
//
// Handshake semantics: RX_D_VLD, RdData_Vaild and ALU_OUT_VLD are single-cycle
// valid pulses with no back-pressure; a pulse is consumed only in the state that
// expects it and is otherwise dropped. TX_D_VLD is a single-cycle pulse issued
// only while TX_BUSY is low; between two TX bytes the sequencer waits for TX_BUSY
// to rise and then fall, so TX_BUSY acts as the inverted ready of the TX side.
// ---------------------------------------------------------------------------
module regfile_cmd_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               CLK,
  input  logic               RST,
  regfile_cmd_if.master      bus,
  output logic [3:0]         dbg_state_o
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_ADDR  = 4'd1,
    WR_DATA  = 4'd2,
    RD_ADDR  = 4'd3,
    RD_WAIT  = 4'd4,
    OP_A     = 4'd5,
    OP_B     = 4'd6,
    FUN      = 4'd7,
    ALU_WAIT = 4'd8,
    TX_LO    = 4'd9,
    TX_HI    = 4'd10
  } state_t;

  localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_OPS = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_FUN = DATA_WIDTH'(8'hDD);

  // TX sub-phase: ready to pulse / waiting for BUSY to rise / waiting for it to fall
  typedef enum logic [1:0] {
    PH_SEND      = 2'd0,
    PH_WAIT_RISE = 2'd1,
    PH_WAIT_FALL = 2'd2
  } tx_ph_t;

  state_t                  state_q;
  tx_ph_t                  tx_ph_q;
  logic                    two_byte_q;   // ALU result: send both bytes
  logic [2*DATA_WIDTH-1:0] tx_buf_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    wr_en_q;
  logic                    rd_en_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;
  logic [FUN_WIDTH-1:0]    alu_fun_q;
  logic                    alu_en_q;
  logic [DATA_WIDTH-1:0]   tx_data_q;
  logic                    tx_vld_q;
  logic                    timeout_hit;

  assign bus.Address   = addr_q;
  assign bus.WR_En     = wr_en_q;
  assign bus.RD_EN     = rd_en_q;
  assign bus.WrData    = wr_data_q;
  assign bus.ALU_FUN   = alu_fun_q;
  assign bus.ALU_EN    = alu_en_q;
  assign bus.TX_P_DATA = tx_data_q;
  assign bus.TX_D_VLD  = tx_vld_q;
  assign dbg_state_o   = state_q;

`ifdef REGFILE_CMD_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] to_cnt_q;
  logic          in_frame;

  // States that are waiting for the next byte of a partially received frame
  assign in_frame = (state_q == WR_ADDR) || (state_q == WR_DATA) ||
                    (state_q == RD_ADDR) || (state_q == OP_A)    ||
                    (state_q == OP_B)    || (state_q == FUN);

  assign timeout_hit = in_frame && !bus.RX_D_VLD && (to_cnt_q == TO_LAST);

  always_ff @(posedge CLK) begin
    if (RST || bus.RX_D_VLD || !in_frame || timeout_hit) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      tx_ph_q    <= PH_SEND;
      two_byte_q <= 1'b0;
      tx_buf_q   <= '0;
      addr_q     <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_data_q  <= '0;
      alu_fun_q  <= '0;
      alu_en_q   <= 1'b0;
      tx_data_q  <= '0;
      tx_vld_q   <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      alu_en_q <= 1'b0;
      tx_vld_q <= 1'b0;

      if (timeout_hit) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            tx_ph_q <= PH_SEND;
            if (bus.RX_D_VLD) begin
              case (bus.RX_P_DATA)
                CMD_WR:  state_q <= WR_ADDR;
                CMD_RD:  state_q <= RD_ADDR;
                CMD_OPS: state_q <= OP_A;
                CMD_FUN: state_q <= FUN;
                default: state_q <= IDLE;
              endcase
            end
          end
          WR_ADDR: begin
            if (bus.RX_D_VLD) begin
              addr_q  <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
              state_q <= WR_DATA;
            end
          end
          WR_DATA: begin
            if (bus.RX_D_VLD) begin
              wr_data_q <= bus.RX_P_DATA;
              wr_en_q   <= 1'b1;
              state_q   <= IDLE;
            end
          end
          RD_ADDR: begin
            if (bus.RX_D_VLD) begin
              addr_q  <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
              rd_en_q <= 1'b1;
              state_q <= RD_WAIT;
            end
          end
          RD_WAIT: begin
            if (bus.RdData_Vaild) begin
              tx_buf_q   <= {{DATA_WIDTH{1'b0}}, bus.RdData};
              two_byte_q <= 1'b0;
              tx_ph_q    <= PH_SEND;
              state_q    <= TX_LO;
            end
          end
          OP_A: begin
            if (bus.RX_D_VLD) begin
              addr_q    <= ADDR_WIDTH'(0);
              wr_data_q <= bus.RX_P_DATA;
              wr_en_q   <= 1'b1;
              state_q   <= OP_B;
            end
          end
          OP_B: begin
            if (bus.RX_D_VLD) begin
              addr_q    <= ADDR_WIDTH'(1);
              wr_data_q <= bus.RX_P_DATA;
              wr_en_q   <= 1'b1;
              state_q   <= FUN;
            end
          end
          FUN: begin
            if (bus.RX_D_VLD) begin
              alu_fun_q <= bus.RX_P_DATA[FUN_WIDTH-1:0];
              alu_en_q  <= 1'b1;
              state_q   <= ALU_WAIT;
            end
          end
          ALU_WAIT: begin
            if (bus.ALU_OUT_VLD) begin
              tx_buf_q   <= bus.ALU_OUT;
              two_byte_q <= 1'b1;
              tx_ph_q    <= PH_SEND;
              state_q    <= TX_LO;
            end
          end
          TX_LO: begin
            case (tx_ph_q)
              PH_SEND: begin
                if (!bus.TX_BUSY) begin
                  tx_data_q <= tx_buf_q[DATA_WIDTH-1:0];
                  tx_vld_q  <= 1'b1;
                  // A read returns one byte: done without waiting on TX_BUSY
                  if (two_byte_q) tx_ph_q <= PH_WAIT_RISE;
                  else            state_q <= IDLE;
                end
              end
              PH_WAIT_RISE: begin
                if (bus.TX_BUSY) tx_ph_q <= PH_WAIT_FALL;
              end
              PH_WAIT_FALL: begin
                if (!bus.TX_BUSY) begin
                  tx_ph_q <= PH_SEND;
                  state_q <= TX_HI;
                end
              end
              default: tx_ph_q <= PH_SEND;
            endcase
          end
          TX_HI: begin
            if (!bus.TX_BUSY) begin
              tx_data_q <= tx_buf_q[2*DATA_WIDTH-1:DATA_WIDTH];
              tx_vld_q  <= 1'b1;
              state_q   <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
module tb_regfile_cmd_ctrl;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] dbg_state;

  always #5 clk = ~clk;

  regfile_cmd_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4)) bus ();

  regfile_cmd_ctrl #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_ALU_WAIT = 4'd8;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  regs [16];
  int          wr_cnt = 0, rd_cnt = 0, alu_cnt = 0, tx_cnt = 0, excl_err = 0;
  logic [3:0]  last_wr_addr = '0, last_rd_addr = '0, last_alu_fun = '0;
  logic [7:0]  last_wr_data = '0;
  logic        busy_seen = 1'b0, last_gap_busy = 1'b0;
  int          alu_delay = 2, alu_cnt_dn = 0, txm_cnt = 0;
  logic [15:0] alu_result = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor + peripheral models (negedge) ----------------
  always @(negedge clk) begin
    if (bus.WR_En && bus.RD_EN)  excl_err++;
    if (bus.WR_En && bus.ALU_EN) excl_err++;
    if (bus.TX_BUSY) busy_seen = 1'b1;
    if (bus.TX_D_VLD) begin
      tx_cnt++;
      last_gap_busy = busy_seen;
      busy_seen     = 1'b0;
      if (exp_q.size() == 0) check("tx_unexpected", {24'h0, bus.TX_P_DATA}, 32'hFFFF_FFFF);
      else                   check("tx_byte", {24'h0, bus.TX_P_DATA}, {24'h0, exp_q.pop_front()});
    end
    if (bus.WR_En) begin
      wr_cnt++;
      last_wr_addr = bus.Address;
      last_wr_data = bus.WrData;
    end
    if (bus.RD_EN)  begin rd_cnt++;  last_rd_addr = bus.Address; end
    if (bus.ALU_EN) begin alu_cnt++; last_alu_fun = bus.ALU_FUN; end

    // register file: data valid one cycle after RD_EN
    bus.RdData_Vaild = 1'b0;
    if (bus.RD_EN) begin
      bus.RdData       = regs[bus.Address];
      bus.RdData_Vaild = 1'b1;
    end
    if (bus.WR_En) regs[bus.Address] = bus.WrData;

    // ALU: result alu_delay cycles after ALU_EN
    bus.ALU_OUT_VLD = 1'b0;
    if (alu_cnt_dn == 1) begin
      bus.ALU_OUT     = alu_result;
      bus.ALU_OUT_VLD = 1'b1;
    end
    if (alu_cnt_dn > 0) alu_cnt_dn--;
    if (bus.ALU_EN) alu_cnt_dn = alu_delay;

    // UART TX: busy for 4 cycles starting one cycle after each pulse
    if (bus.TX_D_VLD)   txm_cnt = 5;
    else if (txm_cnt > 0) txm_cnt--;
    bus.TX_BUSY = (txm_cnt > 0) && (txm_cnt < 5);
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    @(negedge clk);
    bus.RX_D_VLD  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dbg_state == S_IDLE && exp_q.size() == 0 && txm_cnt == 0) begin
        done = 1'b1;
        break;
      end
    end
    check(tag, {31'h0, done}, 32'h1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_state"}, {28'h0, dbg_state}, {28'h0, S_IDLE});
    check({tag, "_strobes"}, {28'h0, bus.WR_En, bus.RD_EN, bus.ALU_EN, bus.TX_D_VLD}, 32'h0);
    check({tag, "_buses"}, {bus.Address, bus.ALU_FUN, bus.WrData, bus.TX_P_DATA}, 32'h0);
  endtask

  // ---------------- directed tests ----------------
  int wr0, rd0, alu0, tx0;

  task automatic snap();
    wr0 = wr_cnt; rd0 = rd_cnt; alu0 = alu_cnt; tx0 = tx_cnt;
  endtask

  initial begin
    bus.RX_P_DATA = '0; bus.RX_D_VLD = 1'b0; bus.RdData = '0; bus.RdData_Vaild = 1'b0;
    bus.ALU_OUT = '0; bus.ALU_OUT_VLD = 1'b0; bus.TX_BUSY = 1'b0;
    for (int i = 0; i < 16; i++) regs[i] = 8'h00;

    idle(3);
    check_outputs_zero("reset");
    rst = 1'b0;
    idle(2);

    // T1 write AA,05,3C
    snap();
    send_byte(8'hAA);
    send_byte(8'h05);
    send_byte(8'h3C);
    check("t1_wr_latency", {31'h0, bus.WR_En}, 32'h1);
    idle(3);
    check("t1_wr_cnt", wr_cnt - wr0, 1);
    check("t1_wr_addr", {28'h0, last_wr_addr}, 32'h5);
    check("t1_wr_data", {24'h0, last_wr_data}, 32'h3C);
    check("t1_no_tx", tx_cnt - tx0, 0);
    check("t1_state", {28'h0, dbg_state}, {28'h0, S_IDLE});

    // T2 read BB,05 (reg5 holds 0x3C)
    regs[5] = 8'h3C;
    snap();
    exp_q.push_back(8'h3C);
    send_byte(8'hBB);
    send_byte(8'h05);
    wait_done("t2_done");
    check("t2_rd_cnt", rd_cnt - rd0, 1);
    check("t2_rd_addr", {28'h0, last_rd_addr}, 32'h5);
    check("t2_tx_cnt", tx_cnt - tx0, 1);

    // T3 ALU frame CC,07,03,02 -> 0x0015 sent LSB first
    snap();
    alu_result = 16'h0015;
    exp_q.push_back(8'h15);
    exp_q.push_back(8'h00);
    send_byte(8'hCC);
    send_byte(8'h07);
    send_byte(8'h03);
    send_byte(8'h02);
    wait_done("t3_done");
    check("t3_reg0", {24'h0, regs[0]}, 32'h07);
    check("t3_reg1", {24'h0, regs[1]}, 32'h03);
    check("t3_wr_cnt", wr_cnt - wr0, 2);
    check("t3_alu_cnt", alu_cnt - alu0, 1);
    check("t3_alu_fun", {28'h0, last_alu_fun}, 32'h2);
    check("t3_tx_cnt", tx_cnt - tx0, 2);
    check("t3_gap_busy", {31'h0, last_gap_busy}, 32'h1);

    // T4 junk in IDLE, then a byte during ALU_WAIT (DD,09 on current operands)
    snap();
    send_byte(8'h55);
    idle(3);
    check("t4_junk_state", {28'h0, dbg_state}, {28'h0, S_IDLE});
    check("t4_junk_strobes", (wr_cnt - wr0) + (rd_cnt - rd0) + (alu_cnt - alu0) + (tx_cnt - tx0), 0);
    alu_delay  = 8;
    alu_result = 16'hA55A;
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hA5);
    send_byte(8'hDD);
    send_byte(8'h09);
    send_byte(8'hAA);
    check("t4_overlap_state", {28'h0, dbg_state}, {28'h0, S_ALU_WAIT});
    wait_done("t4_done");
    check("t4_alu_fun", {28'h0, last_alu_fun}, 32'h9);
    check("t4_no_wr", wr_cnt - wr0, 0);
    check("t4_tx_cnt", tx_cnt - tx0, 2);
    alu_delay = 2;

    // Address byte wider than the register file is truncated: 0x1F -> 0xF
    snap();
    send_byte(8'hAA);
    send_byte(8'h1F);
    send_byte(8'h44);
    idle(2);
    check("trunc_addr", {28'h0, last_wr_addr}, 32'hF);
    check("trunc_data", {24'h0, regs[15]}, 32'h44);

    // T5 reset mid-frame
    snap();
    send_byte(8'hAA);
    send_byte(8'h05);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("t5_reset");
    rst = 1'b0;
    send_byte(8'h3C);
    idle(3);
    check("t5_no_wr", wr_cnt - wr0, 0);
    check("t5_state", {28'h0, dbg_state}, {28'h0, S_IDLE});
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'h99);
    idle(2);
    check("t5_wr_cnt", wr_cnt - wr0, 1);
    check("t5_wr_addr", {28'h0, last_wr_addr}, 32'h2);
    check("t5_wr_data", {24'h0, last_wr_data}, 32'h99);

`ifdef REGFILE_CMD_TIMEOUT_EN
    // T6 timeout: AA then silence abandons the frame; BB,05 is a clean read
    snap();
    send_byte(8'hAA);
    idle(20);
    check("t6_to_state", {28'h0, dbg_state}, {28'h0, S_IDLE});
    exp_q.push_back(8'h3C);
    send_byte(8'hBB);
    send_byte(8'h05);
    wait_done("t6_done");
    check("t6_no_wr", wr_cnt - wr0, 0);
    check("t6_rd_cnt", rd_cnt - rd0, 1);
    check("t6_tx_cnt", tx_cnt - tx0, 1);
`endif

    check("strobe_exclusive", excl_err, 0);
    check("exp_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
